mux_output_checker: RTL and testbench
=====================================

// Module: mux_output_checker
// PURPOSE
//  Lock-step equivalence checker for the 2:1 mux. It compares the behavioural mux outputs (suffix _c)
//  against the synthesized structural outputs (suffix _e) every clock.
//  It flags data and valid mismatches as registered pass/fail bits.
//  It sits inside the mux test harness, beside both mux instances; it is not part of the mux datapath.
// PARAMETERS
//  DATA_W  8   width of data_out_c / data_out_e
//  CNT_W   8   width of the mismatch counter (used only with CHECKER_COUNT_EN)
// PORTS
//  clk             in   1       single clock; all state updates on posedge
//  reset_L         in   1       synchronous reset, ACTIVE-HIGH (asserted = 1) despite the _L name
//  data_out_c      in   DATA_W  behavioural mux data output
//  data_out_e      in   DATA_W  structural mux data output
//  valid_out_c     in   1       behavioural mux valid output
//  valid_out_e     in   1       structural mux valid output
//  check_data_out  out  1       1 = data agree on previous cycle, 0 = data mismatch
//  check_valid     out  1       1 = valids agree on previous cycle, 0 = valid mismatch
//  err_sticky      out  1       1 once any mismatch seen since reset (CHECKER_COUNT_EN only)
//  err_count       out  CNT_W   number of mismatching cycles since reset (CHECKER_COUNT_EN only)
// BEHAVIOUR
//  - Clocking: one clock domain, no combinational input-to-output path, latency exactly 1 cycle.
//  - Reset (reset_L==1 at posedge): check_data_out=1, check_valid=1, err_sticky=0, err_count=0.
//    Inputs are ignored during reset; the first compare result appears on the cycle after reset deasserts.
//  - check_valid <= (valid_out_c == valid_out_e).
//  - check_data_out compares data only when it is qualified:
//      if (valid_out_c | valid_out_e)  check_data_out <= (data_out_c == data_out_e)
//      else                            check_data_out <= 1   (data is don't-care while both valids are low)
//  - A valid mismatch with equal data gives check_valid=0 and check_data_out=1. The two flags are independent.
//  - Equality is full-width and bitwise; there is no masking or partial compare.
//  - A mismatch cycle is a cycle where either computed flag is 0. It is counted once per cycle, even if both flags fail.
//  - err_count saturates at 2**CNT_W-1 and does not wrap.
//  - err_sticky sets on the first mismatch cycle; it is cleared only by reset.
//  - Reset mid-operation takes priority: it clears every output on the same posedge.
//    Any mismatch present in that cycle is discarded.
// CONFIGURATION
//  - Macro CHECKER_COUNT_EN.
//  - Defined: err_sticky and err_count are implemented as described in BEHAVIOUR.
//  - Undefined: no counter or sticky flop is built; err_sticky=0 and err_count=0 constantly.
//    check_data_out and check_valid are unaffected by the macro.
// STRUCTURE
//  - Package mux_checker_pkg holds:
//      DATA_W_DEF=8, CNT_W_DEF=8, typedef logic [DATA_W_DEF-1:0] mux_data_t,
//      and localparam PASS=1'b1 / FAIL=1'b0.
//  - Sub-module mux_checker_cmp is the one natural split: a registered single-lane comparator.
//    Inputs: a, b, qualify. Output: registered match flag.
//    It is instantiated twice: once for data (qualify = valid_c|valid_e), once for valid (qualify tied 1).
//  - The top level adds the mismatch-cycle detect and the optional counter/sticky logic.
// TESTING
//  1. Reset held 2 cycles with data_c=8'hFF, data_e=8'h00, both valids 1
//     -> check_data_out=1, check_valid=1, err_count=0 throughout.
//  2. Release reset; drive valid_c=valid_e=1 and data 8'hFF, 8'hEE, 8'hDD on both sides
//     -> check_data_out=1, check_valid=1 each following cycle.
//  3. valid_c=valid_e=1, data_c=8'hAA, data_e=8'h55
//     -> next cycle check_data_out=0, check_valid=1, err_sticky=1, err_count=1.
//  4. valid_c=1, valid_e=0, data both 8'h33
//     -> next cycle check_valid=0, check_data_out=1; err_count increments by 1.
//  5. Both valids 0, data_c=8'h11, data_e=8'h22
//     -> check_data_out=1, check_valid=1; err_count unchanged.
//  6. With CHECKER_COUNT_EN and CNT_W=2, force 5 mismatch cycles -> err_count=3 (saturated).
//     Then pulse reset_L=1 for one cycle -> err_count=0, err_sticky=0.

Source files
------------

// File: rtl/mux_checker_pkg.sv
// Shared types and constants for the 2:1 mux lock-step equivalence checker.
package mux_checker_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 8;

    typedef logic [DATA_W_DEF-1:0] mux_data_t;

    // Polarity of the per-lane compare flags.
    localparam logic PASS = 1'b1;
    localparam logic FAIL = 1'b0;

endpackage

// File: rtl/mux_checker_cmp.sv
// Registered single-lane comparator. When qualify_i is low the lane is
// treated as a don't-care and reports PASS. match_d_o exposes the value that
// will be registered on the next edge, so the parent can act on it in the same cycle.
module mux_checker_cmp
    import mux_checker_pkg::*;
#(
    parameter int unsigned W = DATA_W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         qualify_i,
    output logic         match_d_o,
    output logic         match_o
);

    logic match_q;

    // Full-width bitwise equality, forced to PASS when the lane is unqualified.
    always_comb begin
        match_d_o = PASS;
        if (qualify_i) begin
            match_d_o = (a_i == b_i) ? PASS : FAIL;
        end
    end

    // Register the compare result; synchronous active-high reset to PASS.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            match_q <= PASS;
        end else begin
            match_q <= match_d_o;
        end
    end

    assign match_o = match_q;

endmodule

// File: rtl/mux_output_checker.sv
// Lock-step equivalence checker: compares behavioural (_c) and structural (_e)
// 2:1 mux outputs every clock and reports registered pass/fail flags.
// Optional error counter and sticky flag are built only when CHECKER_COUNT_EN
// is defined; otherwise err_sticky and err_count are tied to zero.
// Note: reset_L is active-high despite its name.
module mux_output_checker
    import mux_checker_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_out_c,
    input  logic [DATA_W-1:0] data_out_e,
    input  logic              valid_out_c,
    input  logic              valid_out_e,
    output logic              check_data_out,
    output logic              check_valid,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_count
);

    logic data_match_d;
    logic valid_match_d;

    // Data lane: only meaningful while at least one side claims valid.
    mux_checker_cmp #(
        .W (DATA_W)
    ) u_cmp_data (
        .clk_i     (clk),
        .rst_i     (reset_L),
        .a_i       (data_out_c),
        .b_i       (data_out_e),
        .qualify_i (valid_out_c | valid_out_e),
        .match_d_o (data_match_d),
        .match_o   (check_data_out)
    );

    // Valid lane: always compared.
    mux_checker_cmp #(
        .W (1)
    ) u_cmp_valid (
        .clk_i     (clk),
        .rst_i     (reset_L),
        .a_i       (valid_out_c),
        .b_i       (valid_out_e),
        .qualify_i (1'b1),
        .match_d_o (valid_match_d),
        .match_o   (check_valid)
    );

`ifdef CHECKER_COUNT_EN
    logic             mismatch;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    // One mismatch event per cycle regardless of how many lanes fail.
    assign mismatch = (data_match_d == FAIL) || (valid_match_d == FAIL);

    // Saturating count and sticky set on any mismatch cycle.
    always_comb begin
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        if (mismatch) begin
            err_sticky_d = 1'b1;
            if (err_count_q != {CNT_W{1'b1}}) begin
                err_count_d = err_count_q + 1'b1;
            end
        end
    end

    // Reset wins over any mismatch present in the same cycle.
    always_ff @(posedge clk) begin
        if (reset_L) begin
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;
`else
    // Lane match values are consumed only by the counter logic.
    logic unused_match;
    assign unused_match = data_match_d ^ valid_match_d;

    assign err_sticky = 1'b0;
    assign err_count  = '0;
`endif

endmodule

// File: tb/tb_mux_output_checker.sv
// Directed self-checking bench for mux_output_checker (CNT_W=2 so saturation
// is reachable). Counter/sticky expectations follow CHECKER_COUNT_EN.
module tb_mux_output_checker;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 2;

    logic              clk = 1'b0;
    logic              reset_L;
    logic [DATA_W-1:0] data_out_c, data_out_e;
    logic              valid_out_c, valid_out_e;
    logic              check_data_out, check_valid, err_sticky;
    logic [CNT_W-1:0]  err_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_output_checker #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .reset_L        (reset_L),
        .data_out_c     (data_out_c),
        .data_out_e     (data_out_e),
        .valid_out_c    (valid_out_c),
        .valid_out_e    (valid_out_e),
        .check_data_out (check_data_out),
        .check_valid    (check_valid),
        .err_sticky     (err_sticky),
        .err_count      (err_count)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, clock it, then sample 1 time unit after the edge.
    task automatic step(input logic rst, input logic vc, input logic ve,
                        input logic [DATA_W-1:0] dc, input logic [DATA_W-1:0] de);
        reset_L     = rst;
        valid_out_c = vc;
        valid_out_e = ve;
        data_out_c  = dc;
        data_out_e  = de;
        @(posedge clk);
        #1;
    endtask

    // exp_cnt is the hand-derived mismatch count; zero when the counter is not built.
    task automatic expect_all(input string tag, input int exp_d, input int exp_v,
                              input int exp_cnt);
        int c;
        int s;
`ifdef CHECKER_COUNT_EN
        c = exp_cnt;
        s = (exp_cnt != 0) ? 1 : 0;
`else
        c = 0;
        s = 0;
`endif
        check_eq({tag, ".data"},   int'(check_data_out), exp_d);
        check_eq({tag, ".valid"},  int'(check_valid),    exp_v);
        check_eq({tag, ".count"},  int'(err_count),      c);
        check_eq({tag, ".sticky"}, int'(err_sticky),     s);
    endtask

    initial begin
        reset_L     = 1'b1;
        valid_out_c = 1'b0;
        valid_out_e = 1'b0;
        data_out_c  = '0;
        data_out_e  = '0;

        // 1. Reset held 2 cycles with mismatching inputs: outputs stay clean.
        step(1'b1, 1'b1, 1'b1, 8'hFF, 8'h00);  expect_all("rst0", 1, 1, 0);
        step(1'b1, 1'b1, 1'b1, 8'hFF, 8'h00);  expect_all("rst1", 1, 1, 0);

        // 2. Matching traffic.
        step(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);  expect_all("eqFF", 1, 1, 0);
        step(1'b0, 1'b1, 1'b1, 8'hEE, 8'hEE);  expect_all("eqEE", 1, 1, 0);
        step(1'b0, 1'b1, 1'b1, 8'hDD, 8'hDD);  expect_all("eqDD", 1, 1, 0);

        // 3. Data mismatch with both valid.
        step(1'b0, 1'b1, 1'b1, 8'hAA, 8'h55);  expect_all("dmis", 0, 1, 1);

        // 4. Valid mismatch, equal data.
        step(1'b0, 1'b1, 1'b0, 8'h33, 8'h33);  expect_all("vmis", 1, 0, 2);

        // 5. Both valids low: data is don't-care.
        step(1'b0, 1'b0, 1'b0, 8'h11, 8'h22);  expect_all("idle", 1, 1, 2);

        // Only the structural side valid still qualifies data; single-bit MSB difference.
        // Both flags fail, counted once: 2 -> 3.
        step(1'b0, 1'b0, 1'b1, 8'h80, 8'h00);  expect_all("both", 0, 0, 3);

        // Reset pulse with a mismatch present: mismatch discarded.
        step(1'b1, 1'b1, 1'b0, 8'h01, 8'h02);  expect_all("rstm", 1, 1, 0);

        // Double-fail cycle after reset counts once: 0 -> 1.
        step(1'b0, 1'b1, 1'b0, 8'h0F, 8'hF0);  expect_all("dbl1", 0, 0, 1);
        step(1'b0, 1'b1, 1'b1, 8'h42, 8'h42);  expect_all("hold", 1, 1, 1);

        // 6. Five more mismatch cycles: 2, 3, then saturate at 3.
        step(1'b0, 1'b1, 1'b1, 8'h01, 8'h00);  expect_all("sat1", 0, 1, 2);
        step(1'b0, 1'b1, 1'b1, 8'h02, 8'h00);  expect_all("sat2", 0, 1, 3);
        step(1'b0, 1'b1, 1'b0, 8'h04, 8'h04);  expect_all("sat3", 1, 0, 3);
        step(1'b0, 1'b1, 1'b1, 8'h08, 8'h00);  expect_all("sat4", 0, 1, 3);
        step(1'b0, 1'b0, 1'b1, 8'h10, 8'h00);  expect_all("sat5", 0, 0, 3);

        // One-cycle reset pulse clears the counter and sticky.
        step(1'b1, 1'b1, 1'b1, 8'hAA, 8'h55);  expect_all("clr", 1, 1, 0);
        step(1'b0, 1'b0, 1'b0, 8'hAA, 8'h55);  expect_all("post", 1, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
